// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the neural-layer datapath blocks.
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_NUM_NEURON = 30;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // Index width with a floor of one bit so a single-element vector still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_hold_reg.sv
// Single-entry vector holding register: load captures data, clear empties it.
module vector_hold_reg #(
    parameter int W = 480
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/layer_serializer.sv
// Serializes a parallel layer-output vector into NUM_NEURON valid/ready beats.
// Define LAYER_SERIALIZER_DBUF_EN to add a one-deep pending vector buffer.
module layer_serializer
    import nn_pkg::*;
#(
    parameter  int NUM_NEURON = NN_NUM_NEURON,
    parameter  int DATA_WIDTH = NN_DATA_WIDTH,
    localparam int IW         = idx_width(NUM_NEURON),
    localparam int VW         = NUM_NEURON * DATA_WIDTH
) (
    input  logic                  s_axi_aclk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [VW-1:0]         in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IW-1:0]         out_index,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURON - 1);

    ser_state_e    state_q;
    logic [IW-1:0] idx_q;
    logic [VW-1:0] hold_q;
    logic          out_valid_q;
    logic          overrun_q;

    logic          pend_valid;
    logic [VW-1:0] pend_data;
    logic          accept;
    logic          beat_hs;
    logic          last_hs;

    assign accept  = in_valid && in_ready;
    assign beat_hs = out_valid_q && out_ready;
    assign last_hs = beat_hs && (idx_q == LAST_IDX);

`ifdef LAYER_SERIALIZER_DBUF_EN
    logic pend_load;
    logic pend_clear;

    assign in_ready = !pend_valid;
    // A vector arriving on the last beat bypasses pending and loads straight into hold.
    assign pend_load  = accept && (state_q == SEND) && !last_hs;
    assign pend_clear = last_hs && pend_valid;

    vector_hold_reg #(.W(VW)) u_pend (
        .clk_i   (s_axi_aclk),
        .rst_i   (reset),
        .load_i  (pend_load),
        .clear_i (pend_clear),
        .data_i  (in_data),
        .valid_o (pend_valid),
        .data_o  (pend_data)
    );
`else
    assign in_ready   = (state_q == IDLE);
    assign pend_valid = 1'b0;
    assign pend_data  = '0;
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (in_valid && !in_ready)
                overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hold_q      <= in_data;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        if (pend_valid) begin
                            hold_q <= pend_data;
                            idx_q  <= '0;
                        end else if (accept) begin
                            hold_q <= in_data;
                            idx_q  <= '0;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end else if (beat_hs) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = hold_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (idx_q == LAST_IDX);
    assign out_index = idx_q;
    assign busy      = (state_q == SEND) || pend_valid;
    assign overrun   = overrun_q;

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NUM_NEURON, default 30, number of DATA_WIDTH elements per input vector; legal range is 1 or more.
REQ-002 Parameter DATA_WIDTH, default 16, width of one neuron output element.
REQ-003 s_axi_aclk  input  1  clock; all logic samples on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, clock s_axi_aclk.
REQ-005 in_valid  input  1  parallel layer-output vector present.
REQ-006 in_data  input  NUM_NEURON*DATA_WIDTH  vector; element k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_ready  output  1  vector accepted when in_valid and in_ready are both high.
REQ-008 out_data  output  DATA_WIDTH  current serial element.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream accepts a beat when out_valid and out_ready are both high.
REQ-011 out_last  output  1  marks element NUM_NEURON-1 of a vector.
REQ-012 out_index  output  max(1,$clog2(NUM_NEURON))  index k of the current element.
REQ-013 busy  output  1  high in state SEND or while the pending buffer holds a vector.
REQ-014 overrun  output  1  sticky flag: a vector was offered and dropped.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-016 In IDLE, an accepted vector SHALL load the hold register, clear the index, and enter SEND; out_valid SHALL rise on the next cycle with element 0.
REQ-017 In SEND, out_valid SHALL stay high; out_data and out_index SHALL hold steady until a handshake.
REQ-018 Each handshake SHALL advance the index by 1, so exactly NUM_NEURON beats are emitted per vector, with no extra or repeated beat.
REQ-019 out_last SHALL equal (out_valid && index==NUM_NEURON-1); when NUM_NEURON=1, every beat SHALL be last.
REQ-020 A handshake on the last beat SHALL return the FSM to IDLE, unless a next vector is available under REQ-027.
REQ-021 When out_ready is low, the beat SHALL be held indefinitely, without loss or change of data.
REQ-022 in_valid while in_ready is low SHALL drop that vector and set overrun to 1 on the next cycle; overrun SHALL clear only on reset.
REQ-023 The index SHALL never exceed NUM_NEURON-1 and SHALL wrap to 0 only on loading a new vector.
REQ-024 Element selection SHALL be an index-based mux or right shift by DATA_WIDTH; out_data SHALL carry no sign extension or width change.

Reset
REQ-025 Reset SHALL force state=IDLE, index=0, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, pending empty, and in_ready=1 on the next cycle.
REQ-026 Reset asserted mid-vector SHALL discard the remaining beats and any pending vector, with no further out_valid until a new vector is accepted.

Configuration
REQ-027 Macro LAYER_SERIALIZER_DBUF_EN defined: one pending vector buffer is added.
- in_ready = pending empty.
- A vector accepted during SEND goes to pending.
- On the last-beat handshake, pending (or an in_valid vector accepted in that same cycle with pending empty) loads directly, with zero bubble: out_valid stays high and index returns to 0.
REQ-028 Macro undefined: in_ready = (state==IDLE) and there is no pending buffer; there is exactly one idle cycle between consecutive vectors.

Structure
REQ-029 The shared package nn_pkg SHALL hold the IDLE/SEND state encoding and the default DATA_WIDTH and NUM_NEURON constants.
REQ-030 The pending buffer SHALL be a sub-module vector_hold_reg (load, clear, valid, data); all other logic SHALL be flat.

Verification
REQ-031 NUM_NEURON=4, DATA_WIDTH=16, in_data={16'h0004,16'h0003,16'h0002,16'h0001}, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle after acceptance, with out_last only on 4 and exactly 4 beats.
REQ-032 Same vector, out_ready toggled 1,0,0,1,... -> the same 4 values in order, each held stable while out_ready=0.
REQ-033 DBUF off, second vector offered while in SEND -> in_ready=0, overrun=1 next cycle, and only the first vector's 4 beats appear.
REQ-034 DBUF on, two back-to-back vectors (1..4 then 5..8), out_ready=1 -> 8 contiguous beats, with out_last on 4 and 8 and overrun=0.
REQ-035 Reset asserted after beat 2 of vector 1..4 -> out_valid=0 the next cycle; a new vector 9..12 then streams 9,10,11,12 from index 0.
REQ-036 NUM_NEURON=1, vector 16'h00AA -> a single beat 16'h00AA with out_last=1 and out_index=0.
